mpc_sequencer: RTL and testbench
================================

# mpc_sequencer

Instruction sequencer for the 12-bit reversible microprocessor datapath. It is the control end of the datapath's strobe interface: it fetches 12-bit instruction words from instruction memory at the datapath's current PC (ADDR_OUT) and decodes each one into single-cycle CIN / CTRL_* / WE_* / DATA_IN strobes. It sits between instruction memory and the datapath, replacing hand-driven stimulus in system-level runs.

## Interface
- IMM_W, 9, immediate field width; DATA_IN = zero-extended immediate
- CNT_W, 16, retired-instruction counter width
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high
- RUN  in  1  level; 1 = leave IDLE and execute
- ADDR_OUT  in  12  datapath PC
- OVF  in  1  datapath overflow
- IMEM_ADDR  out  12  fetch address; equals ADDR_OUT (combinational passthrough)
- IMEM_REQ  out  1  fetch request
- IMEM_ACK  in  1  one-cycle acknowledge; IMEM_DATA valid in the same cycle
- IMEM_DATA  in  12  instruction word
- CIN, CTRL_A, CTRL_ADDR, CTRL_PC, WE_A, WE_B, WE_PC  out  1 each  datapath strobes
- DATA_IN  out  12  datapath operand
- HALTED  out  1  HALT executed
- INSTR_CNT  out  CNT_W  retired-instruction count

## Operation
- Instruction word: [11:9] opcode, [8:0] imm.
  - 000 NOP
  - 001 LDA: CTRL_A=1, WE_A=1, DATA_IN=imm
  - 010 LDB: WE_B=1, DATA_IN=imm
  - 011 ADD: CTRL_A=0, WE_A=1, CIN=0
  - 100 ADC: CTRL_A=0, WE_A=1, CIN=ovf_flag
  - 101 JMP: WE_PC=1, CTRL_PC=1, DATA_IN=imm
  - 110 JOV: same as JMP if ovf_flag=1, otherwise no strobe
  - 111 HALT
- CTRL_ADDR is always 0.
- States: IDLE, FETCH, EXEC, NEXT, HALT.
  - IDLE -> FETCH when RUN=1.
  - FETCH: IMEM_REQ=1 until the IMEM_ACK cycle. On ACK, latch IR and go to EXEC.
  - EXEC: drive the opcode's strobes for exactly one cycle.
    - JMP, or JOV taken -> FETCH.
    - HALT -> HALT.
    - All others -> NEXT.
  - NEXT: WE_PC=1, CTRL_PC=0 (PC increment), one cycle. Then -> FETCH if RUN=1, else IDLE.
  - After JMP or taken JOV, RUN=0 is checked at the FETCH entry: stay out of FETCH and go to IDLE.
  - HALT: HALTED=1, all strobes 0; left only by RESET.
- ovf_flag: internal register.
  - Sampled from OVF at the end of NEXT following ADD/ADC.
  - Unchanged by every other instruction.
- INSTR_CNT increments by 1 on leaving EXEC (HALT included). Wraps 2^CNT_W-1 -> 0.
- Strobes and DATA_IN come from registered state/IR only; no input-to-strobe combinational path.
- DATA_IN is 0 in every cycle where it is not a defined operand.

## Timing
- Reset values:
  - state IDLE
  - all strobes 0, DATA_IN 0, IMEM_REQ 0
  - HALTED 0, INSTR_CNT 0, ovf_flag 0, IR 0
- RESET has priority over all inputs, in every state. Mid-fetch or mid-EXEC, outputs read as reset values in the cycle after the RESET edge; a pending fetch is abandoned.
- Fetch latency: minimum 1 cycle (ACK in the first REQ cycle); unbounded wait otherwise. IMEM_ADDR holds for the whole request.
- Cycles per instruction with zero-wait memory:
  - 3: FETCH, EXEC, NEXT (LDA, LDB, ADD, ADC, NOP, JOV not taken)
  - 2: FETCH, EXEC (JMP, JOV taken)
- IMEM_ACK outside FETCH is ignored.
- RUN falling mid-instruction: the instruction completes, then IDLE at the next fetch boundary.
- JMP target 0x1FF is legal; a PC increment from 0xFFF wraps per datapath. The sequencer does not check it.

## Test plan
- Reset, then RUN=1, memory {0x207, 0x419, 0x600}, zero-wait:
  - EXEC strobes: WE_A/CTRL_A with DATA_IN=0x007, then WE_B with DATA_IN=0x019, then WE_A with CTRL_A=0 and CIN=0.
  - Each instruction is followed by a WE_PC/CTRL_PC=0 pulse.
  - INSTR_CNT=3 after 9 cycles.
- JMP 0x0A5 (word 0xAA5):
  - WE_PC=1, CTRL_PC=1, DATA_IN=0x0A5 in EXEC.
  - No NEXT pulse; the next IMEM_ADDR equals the datapath PC 0x0A5.
- ADD with OVF=1 during NEXT, then JOV 0x010:
  - Jump taken.
  - Repeat with OVF=0: JOV gives no EXEC strobe plus a NEXT increment; the following ADC drives CIN=0.
- IMEM_ACK delayed 4 cycles:
  - IMEM_REQ high for 5 cycles with IMEM_ADDR stable.
  - A stray ACK pulse while in EXEC is ignored.
- HALT (0xE00):
  - HALTED=1 and INSTR_CNT increments.
  - No further IMEM_REQ despite RUN=1.
  - RESET clears HALTED and INSTR_CNT.
- RESET asserted during a FETCH wait:
  - Next cycle IMEM_REQ=0, all strobes 0, state IDLE.
  - With RUN held at 1, fetch restarts one cycle after RESET falls.

Source files
------------

// File: rtl/mpc_sequencer.sv
// Instruction sequencer for the 12-bit reversible datapath: fetches words at the
// datapath PC and turns each one into single-cycle datapath strobes.
module mpc_sequencer #(
  parameter int IMM_W = 9,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RUN,
  input  logic [11:0]      ADDR_OUT,
  input  logic             OVF,
  output logic [11:0]      IMEM_ADDR,
  output logic             IMEM_REQ,
  input  logic             IMEM_ACK,
  input  logic [11:0]      IMEM_DATA,
  output logic             CIN,
  output logic             CTRL_A,
  output logic             CTRL_ADDR,
  output logic             CTRL_PC,
  output logic             WE_A,
  output logic             WE_B,
  output logic             WE_PC,
  output logic [11:0]      DATA_IN,
  output logic             HALTED,
  output logic [CNT_W-1:0] INSTR_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_NEXT,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LDA  = 3'b001,
    OP_LDB  = 3'b010,
    OP_ADD  = 3'b011,
    OP_ADC  = 3'b100,
    OP_JMP  = 3'b101,
    OP_JOV  = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  state_t  state;
  opcode_t ir_op;
  logic    ovf_flag;

  opcode_t     fetch_op;
  logic [11:0] fetch_imm;
  logic        jump_taken;

  assign IMEM_ADDR = ADDR_OUT;
  assign CTRL_ADDR = 1'b0;

  always_comb begin
    fetch_op   = opcode_t'(IMEM_DATA[11:9]);
    fetch_imm  = 12'(IMEM_DATA[IMM_W-1:0]);
    jump_taken = (ir_op == OP_JMP) || ((ir_op == OP_JOV) && ovf_flag);
  end

  // Strobes are registered on entry to EXEC/NEXT and default low every other
  // cycle, so each one is a clean single-cycle pulse with no input-to-output path.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      ir_op     <= OP_NOP;
      ovf_flag  <= 1'b0;
      IMEM_REQ  <= 1'b0;
      CIN       <= 1'b0;
      CTRL_A    <= 1'b0;
      CTRL_PC   <= 1'b0;
      WE_A      <= 1'b0;
      WE_B      <= 1'b0;
      WE_PC     <= 1'b0;
      DATA_IN   <= '0;
      HALTED    <= 1'b0;
      INSTR_CNT <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees the
      // pre-edge values of state and ir_op regardless of statement order.
      CIN     <= 1'b0;
      CTRL_A  <= 1'b0;
      CTRL_PC <= 1'b0;
      WE_A    <= 1'b0;
      WE_B    <= 1'b0;
      WE_PC   <= 1'b0;
      DATA_IN <= '0;

      case (state)
        S_IDLE: begin
          if (RUN) begin
            state    <= S_FETCH;
            IMEM_REQ <= 1'b1;
          end
        end

        S_FETCH: begin
          if (IMEM_ACK) begin
            IMEM_REQ <= 1'b0;
            ir_op    <= fetch_op;
            state    <= S_EXEC;
            case (fetch_op)
              OP_LDA: begin
                CTRL_A  <= 1'b1;
                WE_A    <= 1'b1;
                DATA_IN <= fetch_imm;
              end
              OP_LDB: begin
                WE_B    <= 1'b1;
                DATA_IN <= fetch_imm;
              end
              OP_ADD: WE_A <= 1'b1;
              OP_ADC: begin
                WE_A <= 1'b1;
                CIN  <= ovf_flag;
              end
              OP_JMP: begin
                WE_PC   <= 1'b1;
                CTRL_PC <= 1'b1;
                DATA_IN <= fetch_imm;
              end
              OP_JOV: begin
                if (ovf_flag) begin
                  WE_PC   <= 1'b1;
                  CTRL_PC <= 1'b1;
                  DATA_IN <= fetch_imm;
                end
              end
              default: ;
            endcase
          end
        end

        S_EXEC: begin
          INSTR_CNT <= INSTR_CNT + CNT_W'(1);
          if (ir_op == OP_HALT) begin
            state  <= S_HALT;
            HALTED <= 1'b1;
          end else if (jump_taken) begin
            // The datapath already holds the target, so fetch directly unless RUN dropped.
            state    <= RUN ? S_FETCH : S_IDLE;
            IMEM_REQ <= RUN;
          end else begin
            state <= S_NEXT;
            WE_PC <= 1'b1;
          end
        end

        S_NEXT: begin
          if ((ir_op == OP_ADD) || (ir_op == OP_ADC)) ovf_flag <= OVF;
          state    <= RUN ? S_FETCH : S_IDLE;
          IMEM_REQ <= RUN;
        end

        S_HALT: ;

        default: begin
          state    <= S_IDLE;
          IMEM_REQ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpc_sequencer.sv
// Directed bench for mpc_sequencer: a cycle table for a full program run plus
// hand sequences for delayed fetch, stray ACK, reset mid-fetch and ADC carry-in.
module tb_mpc_sequencer;

  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RESET, RUN, OVF;
  logic [11:0]      ADDR_OUT, IMEM_ADDR, IMEM_DATA, DATA_IN;
  logic             IMEM_REQ, IMEM_ACK;
  logic             CIN, CTRL_A, CTRL_ADDR, CTRL_PC, WE_A, WE_B, WE_PC, HALTED;
  logic [CNT_W-1:0] INSTR_CNT;

  mpc_sequencer #(.IMM_W(9), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .ADDR_OUT(ADDR_OUT), .OVF(OVF),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_REQ(IMEM_REQ), .IMEM_ACK(IMEM_ACK),
    .IMEM_DATA(IMEM_DATA), .CIN(CIN), .CTRL_A(CTRL_A), .CTRL_ADDR(CTRL_ADDR),
    .CTRL_PC(CTRL_PC), .WE_A(WE_A), .WE_B(WE_B), .WE_PC(WE_PC),
    .DATA_IN(DATA_IN), .HALTED(HALTED), .INSTR_CNT(INSTR_CNT)
  );

  always #5 CLK = ~CLK;

  // Instruction memory and a minimal PC model of the datapath.
  logic [11:0] imem [0:4095];
  logic [11:0] pc;
  int          req_age;
  int          ack_delay;
  logic        stray_ack;

  assign ADDR_OUT  = pc;
  assign IMEM_DATA = imem[IMEM_ADDR];
  assign IMEM_ACK  = (IMEM_REQ && (req_age >= ack_delay)) || stray_ack;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc      <= '0;
      req_age <= 0;
    end else begin
      if (WE_PC) pc <= CTRL_PC ? DATA_IN : pc + 12'd1;
      req_age <= (IMEM_REQ && !IMEM_ACK) ? req_age + 1 : 0;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] strb();
    return {CIN, CTRL_A, WE_A, WE_B, WE_PC, CTRL_PC};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " req"}, 32'(IMEM_REQ), 32'd0);
    check({tag, " strobes"}, 32'(strb()), 32'd0);
    check({tag, " data_in"}, 32'(DATA_IN), 32'd0);
    check({tag, " halted"}, 32'(HALTED), 32'd0);
    check({tag, " cnt"}, 32'(INSTR_CNT), 32'd0);
  endtask

  task automatic pulse_reset();
    RUN   = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Strobe field order: {cin, ctrl_a, we_a, we_b, we_pc, ctrl_pc}
  typedef struct {
    logic        run;
    logic        ovf;
    logic        req;
    logic [11:0] addr;
    logic [5:0]  strb;
    logic [11:0] din;
    logic        halted;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [28];

  initial begin
    int req_cnt;

    tbl[0]  = '{1, 0, 0, 12'h000, 6'b000000, 12'h000, 0, 0};  // IDLE
    tbl[1]  = '{1, 0, 1, 12'h000, 6'b000000, 12'h000, 0, 0};  // fetch LDA
    tbl[2]  = '{1, 0, 0, 12'h000, 6'b011000, 12'h007, 0, 0};
    tbl[3]  = '{1, 0, 0, 12'h000, 6'b000010, 12'h000, 0, 1};
    tbl[4]  = '{1, 0, 1, 12'h001, 6'b000000, 12'h000, 0, 1};  // fetch LDB
    tbl[5]  = '{1, 0, 0, 12'h001, 6'b000100, 12'h019, 0, 1};
    tbl[6]  = '{1, 0, 0, 12'h001, 6'b000010, 12'h000, 0, 2};
    tbl[7]  = '{1, 0, 1, 12'h002, 6'b000000, 12'h000, 0, 2};  // fetch ADD
    tbl[8]  = '{1, 0, 0, 12'h002, 6'b001000, 12'h000, 0, 2};
    tbl[9]  = '{1, 1, 0, 12'h002, 6'b000010, 12'h000, 0, 3};  // OVF=1 in NEXT
    tbl[10] = '{1, 0, 1, 12'h003, 6'b000000, 12'h000, 0, 3};  // fetch JOV
    tbl[11] = '{1, 0, 0, 12'h003, 6'b000011, 12'h010, 0, 3};  // taken
    tbl[12] = '{1, 0, 1, 12'h010, 6'b000000, 12'h000, 0, 4};  // fetch JMP
    tbl[13] = '{1, 0, 0, 12'h010, 6'b000011, 12'h0A5, 0, 4};
    tbl[14] = '{1, 0, 1, 12'h0A5, 6'b000000, 12'h000, 0, 5};  // fetch ADD
    tbl[15] = '{1, 0, 0, 12'h0A5, 6'b001000, 12'h000, 0, 5};
    tbl[16] = '{1, 0, 0, 12'h0A5, 6'b000010, 12'h000, 0, 6};  // OVF=0 in NEXT
    tbl[17] = '{1, 0, 1, 12'h0A6, 6'b000000, 12'h000, 0, 6};  // fetch JOV
    tbl[18] = '{1, 0, 0, 12'h0A6, 6'b000000, 12'h000, 0, 6};  // not taken
    tbl[19] = '{1, 0, 0, 12'h0A6, 6'b000010, 12'h000, 0, 7};
    tbl[20] = '{1, 0, 1, 12'h0A7, 6'b000000, 12'h000, 0, 7};  // fetch ADC
    tbl[21] = '{1, 0, 0, 12'h0A7, 6'b001000, 12'h000, 0, 7};  // CIN=0
    tbl[22] = '{1, 0, 0, 12'h0A7, 6'b000010, 12'h000, 0, 8};
    tbl[23] = '{1, 0, 1, 12'h0A8, 6'b000000, 12'h000, 0, 8};  // fetch HALT
    tbl[24] = '{1, 0, 0, 12'h0A8, 6'b000000, 12'h000, 0, 8};
    tbl[25] = '{1, 0, 0, 12'h0A8, 6'b000000, 12'h000, 1, 9};
    tbl[26] = '{1, 0, 0, 12'h0A8, 6'b000000, 12'h000, 1, 9};
    tbl[27] = '{1, 0, 0, 12'h0A8, 6'b000000, 12'h000, 1, 9};

    for (int a = 0; a < 4096; a++) imem[a] = 12'h000;
    imem[12'h000] = 12'h207;
    imem[12'h001] = 12'h419;
    imem[12'h002] = 12'h600;
    imem[12'h003] = 12'hC10;
    imem[12'h010] = 12'hAA5;
    imem[12'h0A5] = 12'h600;
    imem[12'h0A6] = 12'hC10;
    imem[12'h0A7] = 12'h800;
    imem[12'h0A8] = 12'hE00;

    RESET = 1'b1; RUN = 1'b0; OVF = 1'b0; ack_delay = 0; stray_ack = 1'b0;
    repeat (3) @(negedge CLK);
    check_idle_outputs("reset");
    check("reset ctrl_addr", 32'(CTRL_ADDR), 32'd0);
    RESET = 1'b0;

    // Full program run, cycle by cycle.
    for (int i = 0; i < 28; i++) begin
      RUN = tbl[i].run;
      OVF = tbl[i].ovf;
      check($sformatf("row%0d req", i), 32'(IMEM_REQ), 32'(tbl[i].req));
      check($sformatf("row%0d addr", i), 32'(IMEM_ADDR), 32'(tbl[i].addr));
      check($sformatf("row%0d strobes", i), 32'(strb()), 32'(tbl[i].strb));
      check($sformatf("row%0d data_in", i), 32'(DATA_IN), 32'(tbl[i].din));
      check($sformatf("row%0d halted", i), 32'(HALTED), 32'(tbl[i].halted));
      check($sformatf("row%0d cnt", i), 32'(INSTR_CNT), 32'(tbl[i].cnt));
      check($sformatf("row%0d ctrl_addr", i), 32'(CTRL_ADDR), 32'd0);
      @(negedge CLK);
    end

    // RESET leaves HALT and clears the counter.
    pulse_reset();
    check_idle_outputs("halt reset");

    // Fetch with ACK in the fifth request cycle, then a stray ACK during EXEC.
    imem[12'h000] = 12'h207;
    ack_delay = 4;
    RUN = 1'b1;
    req_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (IMEM_REQ) begin
        req_cnt++;
        check("delayed addr stable", 32'(IMEM_ADDR), 32'h000);
      end else if (req_cnt > 0) begin
        break;
      end
    end
    check("delayed req cycles", 32'(req_cnt), 32'd5);
    check("delayed exec strobes", 32'(strb()), 32'(6'b011000));
    check("delayed exec data_in", 32'(DATA_IN), 32'h007);
    stray_ack = 1'b1;
    @(negedge CLK);
    stray_ack = 1'b0;
    check("stray ack next strobes", 32'(strb()), 32'(6'b000010));
    check("stray ack next req", 32'(IMEM_REQ), 32'd0);
    check("stray ack cnt", 32'(INSTR_CNT), 32'd1);

    // Reset in the middle of a fetch wait; RUN stays high.
    ack_delay = 100;
    @(negedge CLK);
    check("wait req", 32'(IMEM_REQ), 32'd1);
    check("wait addr", 32'(IMEM_ADDR), 32'h001);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check_idle_outputs("mid-fetch reset");
    @(negedge CLK);
    check("restart req", 32'(IMEM_REQ), 32'd1);
    check("restart addr", 32'(IMEM_ADDR), 32'h000);

    // ADD with overflow feeds CIN=1 to a following ADC; RUN drops during ADC.
    pulse_reset();
    ack_delay = 0;
    imem[12'h000] = 12'h600;
    imem[12'h001] = 12'h800;
    RUN = 1'b1;
    @(negedge CLK);
    check("adc fetch req", 32'(IMEM_REQ), 32'd1);
    @(negedge CLK);
    check("adc add strobes", 32'(strb()), 32'(6'b001000));
    @(negedge CLK);
    OVF = 1'b1;
    check("adc next strobes", 32'(strb()), 32'(6'b000010));
    @(negedge CLK);
    OVF = 1'b0;
    check("adc fetch2 addr", 32'(IMEM_ADDR), 32'h001);
    @(negedge CLK);
    RUN = 1'b0;
    check("adc strobes cin", 32'(strb()), 32'(6'b101000));
    @(negedge CLK);
    check("run-drop next strobes", 32'(strb()), 32'(6'b000010));
    @(negedge CLK);
    check("run-drop idle req", 32'(IMEM_REQ), 32'd0);
    @(negedge CLK);
    check("run-drop idle req2", 32'(IMEM_REQ), 32'd0);
    check("run-drop cnt", 32'(INSTR_CNT), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
